// File: rtl/traceback_stream.sv
// traceback_stream
// Streams the traceback of a banked alignment score matrix.  Starting at the
// bottom-right corner of an L x L sub-problem, each step reads one relative
// position code from a PE bank, emits one aligned base pair (or a gap) and
// moves the pointers, until the top-left corner, a stop code or an illegal
// move ends the alignment.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start, abort         begin a traceback (IDLE only) / synchronous return to IDLE
//   R_sub, Q_sub         packed sequences, base 0 in the MSBs
//   pe_id, addr, rd_en   bank read request; rel_pos is returned one cycle later
//   rel_pos              relative-position code, bits [2:0] used
//   out_r, out_q         aligned pair (gap = 4), out_last marks the final pair
//   out_valid, out_ready stream handshake
//   busy, done, err      status: not idle / one-cycle completion / illegal move
//   aln_len              pairs transferred in the current or last alignment
module traceback_stream #(
    parameter int B = 4,
    parameter int L = 8,
    parameter int W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [W*L-1:0]          R_sub,
    input  logic [W*L-1:0]          Q_sub,
    output logic [$clog2(B)-1:0]    pe_id,
    output logic [7:0]              addr,
    output logic                    rd_en,
    input  logic [7:0]              rel_pos,
    output logic [W-1:0]            out_r,
    output logic [W-1:0]            out_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [$clog2(2*L):0]    aln_len
);
    localparam int PW  = $clog2(B);
    localparam int CW  = $clog2(L);
    localparam int ALW = $clog2(2*L) + 1;

    localparam logic [PW-1:0] PE_INIT   = PW'(B - 1);
    localparam logic [7:0]    ADDR_INIT = 8'(2*L - B - 1);
    localparam logic [CW-1:0] CTR_INIT  = CW'(L - 1);
    localparam logic [W-1:0]  GAP       = W'(4);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EMIT, S_FINISH} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   pe_reg;
    logic [7:0]      addr_reg;
    logic [CW-1:0]   r_ctr_reg, q_ctr_reg;
    logic [W*L-1:0]  r_seq_reg, q_seq_reg;
    logic [W-1:0]    out_r_reg, out_q_reg;
    logic            last_reg, err_reg;
    logic [ALW-1:0]  aln_len_reg;

    // Unpacked views of the captured sequences, indexed by base number.
    logic [W-1:0] r_base [L];
    logic [W-1:0] q_base [L];
    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_unpack
            assign r_base[gi] = r_seq_reg[W*(L-1-gi) +: W];
            assign q_base[gi] = q_seq_reg[W*(L-1-gi) +: W];
        end
    endgenerate

    logic [W-1:0] r_cur, q_cur;
    assign r_cur = r_base[r_ctr_reg];
    assign q_cur = q_base[q_ctr_reg];

    logic corner;
    assign corner = (r_ctr_reg == '0) && (q_ctr_reg == '0);

    // Only the low three bits carry a move; the rest is ignored.
    logic [2:0] code;
    logic       rel_pos_unused;
    assign code           = rel_pos[2:0];
    assign rel_pos_unused = ^rel_pos[7:3];

    // Move decode: candidate pointers, gap flags and stop condition.
    logic [PW-1:0] pe_dec;
    logic [7:0]    addr_dec;
    logic [CW-1:0] r_dec, q_dec;
    logic          gap_r, gap_q, dec_last, dec_legal;

    always_comb begin
        pe_dec    = pe_reg;
        addr_dec  = addr_reg;
        r_dec     = r_ctr_reg;
        q_dec     = q_ctr_reg;
        gap_r     = 1'b0;
        gap_q     = 1'b0;
        dec_last  = 1'b0;
        dec_legal = 1'b1;
        case (code)
            3'd1: begin
                dec_legal = (q_ctr_reg != '0) && (pe_reg != '0);
                gap_r = 1'b1; pe_dec = pe_reg - PW'(1); q_dec = q_ctr_reg - CW'(1);
            end
            3'd2: begin
                dec_legal = (r_ctr_reg != '0);
                gap_q = 1'b1; addr_dec = addr_reg - 8'd1; r_dec = r_ctr_reg - CW'(1);
            end
            3'd3: begin
                dec_legal = (r_ctr_reg != '0) && (q_ctr_reg != '0) && (pe_reg != '0);
                pe_dec = pe_reg - PW'(1); addr_dec = addr_reg - 8'd1;
                r_dec = r_ctr_reg - CW'(1); q_dec = q_ctr_reg - CW'(1);
            end
            3'd4: begin
                dec_legal = (r_ctr_reg != '0) && (q_ctr_reg != '0);
                addr_dec = addr_reg - 8'd2;
                r_dec = r_ctr_reg - CW'(1); q_dec = q_ctr_reg - CW'(1);
            end
            3'd5: begin
                dec_legal = (q_ctr_reg != '0);
                gap_r = 1'b1; addr_dec = addr_reg - 8'd1; q_dec = q_ctr_reg - CW'(1);
            end
            3'd6: begin
                dec_legal = (r_ctr_reg != '0) && (pe_reg != PE_INIT);
                gap_q = 1'b1; pe_dec = pe_reg + PW'(1); addr_dec = addr_reg - 8'd2;
                r_dec = r_ctr_reg - CW'(1);
            end
            default: dec_last = 1'b1;   // 0 and 7: stop here
        endcase
        // An illegal move freezes the pointers and ends the alignment on (R,Q).
        if (!dec_legal) begin
            pe_dec   = pe_reg;
            addr_dec = addr_reg;
            r_dec    = r_ctr_reg;
            q_dec    = q_ctr_reg;
            gap_r    = 1'b0;
            gap_q    = 1'b0;
            dec_last = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  state_next = corner ? S_EMIT : S_DECODE;
            S_DECODE: state_next = S_EMIT;
            S_EMIT:   if (out_ready) state_next = last_reg ? S_FINISH : S_FETCH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    // Output logic
    always_comb begin
        rd_en     = (state_reg == S_FETCH) && !corner;
        out_valid = (state_reg == S_EMIT);
        busy      = (state_reg != S_IDLE);
        done      = (state_reg == S_FINISH);
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_reg      <= PE_INIT;
            addr_reg    <= ADDR_INIT;
            r_ctr_reg   <= CTR_INIT;
            q_ctr_reg   <= CTR_INIT;
            r_seq_reg   <= '0;
            q_seq_reg   <= '0;
            out_r_reg   <= '1;
            out_q_reg   <= '1;
            last_reg    <= 1'b0;
            err_reg     <= 1'b0;
            aln_len_reg <= '0;
        end else if (abort) begin
            pe_reg    <= PE_INIT;
            addr_reg  <= ADDR_INIT;
            r_ctr_reg <= CTR_INIT;
            q_ctr_reg <= CTR_INIT;
            last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: if (start) begin
                    r_seq_reg   <= R_sub;
                    q_seq_reg   <= Q_sub;
                    pe_reg      <= PE_INIT;
                    addr_reg    <= ADDR_INIT;
                    r_ctr_reg   <= CTR_INIT;
                    q_ctr_reg   <= CTR_INIT;
                    last_reg    <= 1'b0;
                    err_reg     <= 1'b0;
                    aln_len_reg <= '0;
                end
                S_FETCH: if (corner) begin
                    out_r_reg <= r_base[0];
                    out_q_reg <= q_base[0];
                    last_reg  <= 1'b1;
                end
                S_DECODE: begin
                    pe_reg    <= pe_dec;
                    addr_reg  <= addr_dec;
                    r_ctr_reg <= r_dec;
                    q_ctr_reg <= q_dec;
                    out_r_reg <= gap_r ? GAP : r_cur;
                    out_q_reg <= gap_q ? GAP : q_cur;
                    last_reg  <= dec_last;
                    if (!dec_legal) err_reg <= 1'b1;
                end
                S_EMIT: if (out_ready) aln_len_reg <= aln_len_reg + ALW'(1);
                S_FINISH: begin
                    pe_reg    <= PE_INIT;
                    addr_reg  <= ADDR_INIT;
                    r_ctr_reg <= CTR_INIT;
                    q_ctr_reg <= CTR_INIT;
                    last_reg  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign pe_id    = pe_reg;
    assign addr     = addr_reg;
    assign out_r    = out_r_reg;
    assign out_q    = out_q_reg;
    assign out_last = last_reg;
    assign err      = err_reg;
    assign aln_len  = aln_len_reg;

endmodule

// File: tb/tb_traceback_stream.sv
module tb_traceback_stream;
    localparam int B = 4;
    localparam int L = 8;
    localparam int W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [W*L-1:0]   R_sub = '0;
    logic [W*L-1:0]   Q_sub = '0;
    logic [1:0]       pe_id;
    logic [7:0]       addr;
    logic             rd_en;
    logic [7:0]       rel_pos = 8'd0;
    logic [W-1:0]     out_r, out_q;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last, busy, done, err;
    logic [4:0]       aln_len;

    traceback_stream #(.B(B), .L(L), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .R_sub(R_sub), .Q_sub(Q_sub),
        .pe_id(pe_id), .addr(addr), .rd_en(rd_en), .rel_pos(rel_pos),
        .out_r(out_r), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .err(err), .aln_len(aln_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] q;
        logic         last;
    } pair_t;

    pair_t pair_q[$];
    int    read_pe_q[$];
    int    read_addr_q[$];
    int    code_q[$];
    int    stim[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ready_mode = 0;   // 0: always 1, 1: toggle, 2: random, 3: always 0
    int xfer_no = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] base_of(input logic [W*L-1:0] s, input int i);
        return s[W*(L-1-i) +: W];
    endfunction

    // Reference model: walks the matrix with plain integers, producing the
    // expected reads (with the code each returns) and the expected pairs.
    task automatic model(input logic [W*L-1:0] rs, input logic [W*L-1:0] qs,
                         output int n_pairs, output int exp_err);
        int r, q, pe, a, k, c, dr, dq, dp, da;
        bit gr, gq, stop, fin;
        pair_t p;
        r = L - 1; q = L - 1; pe = B - 1; a = 2*L - B - 1; k = 0;
        n_pairs = 0; exp_err = 0; fin = 0;
        while (!fin) begin
            if (r == 0 && q == 0) begin
                p.r = base_of(rs, 0); p.q = base_of(qs, 0); p.last = 1'b1;
                pair_q.push_back(p); n_pairs++; fin = 1;
            end else begin
                c = stim[k]; k++;
                read_pe_q.push_back(pe); read_addr_q.push_back(a & 255); code_q.push_back(c);
                dr = 0; dq = 0; dp = 0; da = 0; gr = 0; gq = 0; stop = 0;
                case (c)
                    1: begin dp = -1; dq = 1; gr = 1; end
                    2: begin da = -1; dr = 1; gq = 1; end
                    3: begin dp = -1; da = -1; dr = 1; dq = 1; end
                    4: begin da = -2; dr = 1; dq = 1; end
                    5: begin da = -1; dq = 1; gr = 1; end
                    6: begin dp = 1; da = -2; dr = 1; gq = 1; end
                    default: stop = 1;
                endcase
                if (!stop && (r - dr < 0 || q - dq < 0 || pe + dp < 0 || pe + dp > B - 1)) begin
                    stop = 1; exp_err = 1;
                end
                if (stop) begin
                    p.r = base_of(rs, r); p.q = base_of(qs, q); p.last = 1'b1;
                    pair_q.push_back(p); n_pairs++; fin = 1;
                end else begin
                    p.r = gr ? W'(4) : base_of(rs, r);
                    p.q = gq ? W'(4) : base_of(qs, q);
                    p.last = 1'b0;
                    pair_q.push_back(p); n_pairs++;
                    r -= dr; q -= dq; pe += dp; a += da;
                end
            end
        end
    endtask

    task automatic fill_stim(input int v);
        stim.delete();
        for (int i = 0; i < 2*L; i++) stim.push_back(v);
    endtask

    task automatic flush_queues();
        pair_q.delete(); read_pe_q.delete(); read_addr_q.delete(); code_q.delete();
    endtask

    // Full alignment: model, start, bounded wait for done, end-of-run checks.
    task automatic run_alignment(input string nm, input int mode, input bit hold_start);
        int n, e, cyc;
        bit got;
        logic [31:0] tmp;
        tmp = $urandom; R_sub = tmp[W*L-1:0];
        tmp = $urandom; Q_sub = tmp[W*L-1:0];
        model(R_sub, Q_sub, n, e);
        ready_mode = mode;
        done_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        cyc = 0; got = 0;
        while (!got && cyc < 400) begin
            @(negedge clk); cyc++;
            if (cyc == 4) start = 1'b0;
            if (done) got = 1;
        end
        chk({nm, "_done_seen"}, int'(got), 1);
        if (mode == 0) chk({nm, "_throughput"}, int'(cyc <= 3*n + 1), 1);
        chk({nm, "_aln_len"}, int'(aln_len), n);
        chk({nm, "_err"}, int'(err), e);
        repeat (2) @(negedge clk);
        chk({nm, "_idle"}, int'(busy), 0);
        chk({nm, "_done_once"}, done_cnt, 1);
        chk({nm, "_pairs_left"}, pair_q.size(), 0);
        chk({nm, "_reads_left"}, read_pe_q.size(), 0);
        flush_queues();
    endtask

    // Read responder: checks each read address and returns its code next cycle.
    initial begin
        bit prev_rd;
        int c;
        logic [31:0] tmp;
        prev_rd = 0;
        forever begin
            @(negedge clk);
            if (!rst && rd_en) begin
                if (prev_rd) chk("rd_en_single_cycle", 1, 0);
                if (read_pe_q.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                    rel_pos = 8'd7;
                end else begin
                    chk("read_pe", int'(pe_id), read_pe_q.pop_front());
                    chk("read_addr", int'(addr), read_addr_q.pop_front());
                    c = code_q.pop_front();
                    tmp = $urandom;
                    rel_pos = {tmp[4:0], c[2:0]};
                end
            end
            prev_rd = rd_en;
        end
    end

    // Output monitor / scoreboard.
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (out_valid) begin
                if (pair_q.size() == 0) begin
                    if (out_ready) chk("unexpected_transfer", 1, 0);
                end else begin
                    p = pair_q[0];
                    if (out_ready) void'(pair_q.pop_front());
                    chk(out_ready ? "pair_r" : "held_r", int'(out_r), int'(p.r));
                    chk(out_ready ? "pair_q" : "held_q", int'(out_q), int'(p.q));
                    chk(out_ready ? "pair_last" : "held_last", int'(out_last), int'(p.last));
                    if (out_ready) begin
                        xfer_no++;
                        $display("transfer %0d: r=%0d q=%0d last=%0d len_before=%0d",
                                 xfer_no, out_r, out_q, out_last, aln_len);
                    end
                end
            end
        end
    end

    // out_ready driver.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        int k, v, cyc;
        bit got;
        // Reset state
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_pe", int'(pe_id), 3);
        chk("rst_addr", int'(addr), 11);
        chk("rst_out_r", int'(out_r), 7);
        chk("rst_out_q", int'(out_q), 7);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_flags", int'({out_last, rd_en, done, err}), 0);
        chk("rst_aln_len", int'(aln_len), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // All reads return 3: pe walks down and goes illegal on the 4th read
        fill_stim(3);
        run_alignment("all3", 0, 1'b0);
        // All 4s: diagonal to the corner, start held high (must be ignored)
        fill_stim(4);
        run_alignment("all4", 0, 1'b1);
        // Immediate stop
        fill_stim(7);
        run_alignment("first7", 0, 1'b0);
        fill_stim(0);
        run_alignment("first0", 2, 1'b0);
        // Gap moves under a toggling out_ready
        fill_stim(7); stim[0] = 5; stim[1] = 2;
        run_alignment("gaps_toggle", 1, 1'b0);
        // Code 6 pushes pe past B-1 at the first read
        fill_stim(6);
        run_alignment("all6", 0, 1'b0);

        // Abort while in DECODE
        ready_mode = 0; done_cnt = 0;
        read_pe_q.push_back(3); read_addr_q.push_back(11); code_q.push_back(3);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk); cyc++;
            if (rd_en) got = 1;
        end
        chk("abort_read_seen", int'(got), 1);
        @(posedge clk); #1 abort = 1'b1;      // now in DECODE
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_idle", int'(busy), 0);
        chk("abort_no_valid", int'(out_valid), 0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_aln_len", int'(aln_len), 0);
        flush_queues();

        // Asynchronous reset while stalled in EMIT, then a fresh alignment
        fill_stim(4);
        R_sub = 24'h123456; Q_sub = 24'hfedcba;
        begin
            int n, e;
            model(R_sub, Q_sub, n, e);
        end
        ready_mode = 3;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk); cyc++;
            if (out_valid) got = 1;
        end
        chk("rst_mid_emit_reached", int'(got), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", int'(out_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_pe", int'(pe_id), 3);
        chk("rst_mid_addr", int'(addr), 11);
        chk("rst_mid_out_r", int'(out_r), 7);
        flush_queues();
        ready_mode = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_output", int'(out_valid), 0);
        chk("rst_mid_aln_len", int'(aln_len), 0);
        run_alignment("after_rst", 0, 1'b0);

        // Randomized alignments
        for (int t = 0; t < 20; t++) begin
            stim.delete();
            for (int i = 0; i < 2*L; i++) begin
                k = $urandom_range(0, 15);
                case (k)
                    0, 1, 2, 3, 15: v = 4;
                    4, 5, 6:        v = 3;
                    7, 11:          v = 5;
                    8, 12:          v = 2;
                    9:              v = 6;
                    10:             v = 1;
                    13:             v = 0;
                    default:        v = 7;
                endcase
                stim.push_back(v);
            end
            run_alignment($sformatf("rand%0d", t), $urandom_range(0, 2), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
